avr_irq_ctrl: RTL and testbench

- Parametrised vectored interrupt controller for the AVR8 core. Generalises the single built-in timer interrupt into CHANNELS prioritised sources, with per-channel edge/level mode, enable mask, nesting and a timeslice channel.
- Sits between peripheral interrupt lines and the CPU's interrupt-entry sequence. The CPU pushes PC, pulses irq_ack, then jumps to irq_vector.

---
 rtl/avr_irq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_avr_irq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/avr_irq_ctrl.sv
// Vectored, prioritised interrupt controller for the AVR8 core: CHANNELS sources with
// edge/level mode, enable mask, ISR-based nesting and a tick-driven timeslice channel.
module avr_irq_ctrl #(
    parameter int unsigned CHANNELS  = 8,
    parameter logic [15:0] VECT_BASE = 16'h0002,
    parameter int unsigned VECT_STEP = 2,
    parameter int unsigned SLICE_CH  = CHANNELS - 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] irq_src,
    input  logic                tick,
    input  logic                sreg_i,
    input  logic                cpu_idle,
    output logic                irq_req,
    output logic [15:0]         irq_vector,
    output logic [2:0]          irq_id,
    input  logic                irq_ack,
    input  logic                irq_reti,
    input  logic [1:0]          cfg_addr,
    input  logic [7:0]          cfg_wdata,
    input  logic                cfg_we,
    output logic [7:0]          cfg_rdata
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = 9;

    typedef enum logic {ST_IDLE, ST_REQ} state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [15:0]         vec_q, vec_d;
    logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q;
    logic [CHANNELS-1:0] enable_q, enable_d, mode_q, mode_d;
    logic [CHANNELS-1:0] pend_q, pend_d, isr_q, isr_d;
    logic                slice_flag_q, slice_flag_d;
    logic [7:0]          slice_q, slice_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [CHANNELS-1:0] rise, slice_vec, pend_eff, masked, ack_vec, isr_low;
    logic                ack_fire, ack_slice, slice_fire, pend_wr;
    logic                cand_valid, isr_seen;
    logic [ID_W-1:0]     cand_id;
    logic [CNT_W-1:0]    cnt_inc;

    assign rise     = sync2_q & ~sync3_q;
    assign ack_fire = (state_q == ST_REQ) && irq_ack;
    assign pend_wr  = cfg_we && (cfg_addr == 2'd2);
    assign pend_eff = pend_q | slice_vec;
    assign masked   = pend_eff & enable_q;
    assign isr_low  = isr_q & (~isr_q + CHANNELS'(1));
    assign ack_slice = ack_vec[SLICE_CH];
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Timeslice hit is held outside PENDING so it keeps edge semantics in either mode.
    always_comb begin
        slice_vec           = '0;
        slice_vec[SLICE_CH] = slice_flag_q;
    end

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            ack_vec[i] = ack_fire && (id_q == ID_W'(i));
        end
    end

    // Lowest enabled pending channel that sits above the lowest in-service channel.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        isr_seen   = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (!isr_seen && !cand_valid) begin
                if (isr_q[i]) begin
                    isr_seen = 1'b1;
                end else if (masked[i]) begin
                    cand_valid = 1'b1;
                    cand_id    = ID_W'(i);
                end
            end
        end
    end

    // Configuration, pending, in-service and timeslice next state.
    always_comb begin
        enable_d     = enable_q;
        mode_d       = mode_q;
        slice_d      = slice_q;
        cnt_d        = cnt_q;
        slice_fire   = 1'b0;
        slice_flag_d = slice_flag_q;
        pend_d       = pend_q;
        isr_d        = isr_q;

        if (cfg_we && cfg_addr == 2'd0) enable_d = cfg_wdata[CHANNELS-1:0];
        if (cfg_we && cfg_addr == 2'd1) mode_d   = cfg_wdata[CHANNELS-1:0];
        if (cfg_we && cfg_addr == 2'd3) slice_d  = cfg_wdata;

        if (slice_q != 8'd0 && sreg_i && tick) begin
            if (cnt_inc > CNT_W'(slice_q)) slice_fire = 1'b1;
            else                           cnt_d      = cnt_inc;
        end
        if (slice_fire || ack_slice) cnt_d = '0;

        if (pend_wr && cfg_wdata[SLICE_CH]) slice_flag_d = 1'b0;
        if (ack_slice)                      slice_flag_d = 1'b0;
        if (slice_fire)                     slice_flag_d = 1'b1;

        // New edges win over a same-cycle clear.
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (mode_q[i]) begin
                if (pend_wr && cfg_wdata[i]) pend_d[i] = 1'b0;
                if (ack_vec[i])              pend_d[i] = 1'b0;
                if (rise[i])                 pend_d[i] = 1'b1;
            end else begin
                pend_d[i] = sync2_q[i];
            end
        end

        if (irq_reti) isr_d = isr_q & ~isr_low;
        isr_d = isr_d | ack_vec;
    end

    // Request FSM.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_idle && sreg_i && cand_valid) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    id_d    = cand_id;
                    vec_d   = VECT_BASE + 16'(VECT_STEP) * 16'(cand_id);
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            id_q         <= '0;
            vec_q        <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            enable_q     <= '0;
            mode_q       <= '1;
            pend_q       <= '0;
            isr_q        <= '0;
            slice_flag_q <= 1'b0;
            slice_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            id_q         <= id_d;
            vec_q        <= vec_d;
            sync1_q      <= irq_src;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            pend_q       <= pend_d;
            isr_q        <= isr_d;
            slice_flag_q <= slice_flag_d;
            slice_q      <= slice_d;
            cnt_q        <= cnt_d;
        end
    end

    assign irq_req    = req_q;
    assign irq_id     = id_q;
    assign irq_vector = vec_q;

    always_comb begin
        cfg_rdata = 8'h00;
        case (cfg_addr)
            2'd0: cfg_rdata = 8'(enable_q);
            2'd1: cfg_rdata = 8'(mode_q);
            2'd2: cfg_rdata = 8'(pend_eff);
            2'd3: cfg_rdata = slice_q;
            default: cfg_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Directed bench for avr_irq_ctrl: priority, level/edge modes, nesting, timeslice and reset.
module tb_avr_irq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic        tick, sreg_i, cpu_idle, irq_ack, irq_reti, cfg_we;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic [2:0]  irq_id;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata, cfg_rdata;

    int total = 0;
    int bad   = 0;

    avr_irq_ctrl dut (
        .clock(clock), .reset(reset), .irq_src(irq_src), .tick(tick),
        .sreg_i(sreg_i), .cpu_idle(cpu_idle), .irq_req(irq_req),
        .irq_vector(irq_vector), .irq_id(irq_id), .irq_ack(irq_ack),
        .irq_reti(irq_reti), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_we(cfg_we), .cfg_rdata(cfg_rdata)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        chk(tag, 16'(cfg_rdata), 16'(exp));
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [2:0] id, input logic [15:0] v);
        chk({tag, "_req"}, 16'(irq_req), 16'(r));
        if (r) begin
            chk({tag, "_id"}, 16'(irq_id), 16'(id));
            chk({tag, "_vec"}, irq_vector, v);
        end
    endtask

    task automatic pulse_src(input logic [7:0] m);
        irq_src = m;
        step(1);
        irq_src = 8'h00;
    endtask

    task automatic ack();
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    endtask

    task automatic reti();
        irq_reti = 1'b1; step(1); irq_reti = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1; step(1); tick = 1'b0; step(1);
    endtask

    initial begin
        reset = 1'b1; irq_src = 8'h00; tick = 1'b0; sreg_i = 1'b0; cpu_idle = 1'b0;
        irq_ack = 1'b0; irq_reti = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
        step(2);
        chk("rst_req", 16'(irq_req), 16'h0);
        chk("rst_vec", irq_vector, 16'h0);
        chk("rst_id", 16'(irq_id), 16'h0);
        rd_chk("rst_enable", 2'd0, 8'h00);
        rd_chk("rst_mode", 2'd1, 8'hFF);
        rd_chk("rst_pend", 2'd2, 8'h00);
        rd_chk("rst_slice", 2'd3, 8'h00);
        reset = 1'b0; cpu_idle = 1'b1; sreg_i = 1'b1;
        step(1);

        // Simultaneous edges on 5 and 2: 2 wins, 5 follows after ack + reti.
        wr(2'd0, 8'h24);
        pulse_src(8'h24);
        step(2);
        rd_chk("a_pend", 2'd2, 8'h24);
        chk("a_req_early", 16'(irq_req), 16'h0);
        step(1);
        chk_req("a_first", 1'b1, 3'd2, 16'h0006);
        step(2);
        chk_req("a_hold", 1'b1, 3'd2, 16'h0006);
        ack();
        chk("a_ack_req", 16'(irq_req), 16'h0);
        step(3);
        chk("a_blocked", 16'(irq_req), 16'h0);
        rd_chk("a_pend2", 2'd2, 8'h20);
        reti();
        step(1);
        chk_req("a_second", 1'b1, 3'd5, 16'h000C);
        ack(); reti();

        // Channel 3 level mode.
        wr(2'd1, 8'hF7);
        wr(2'd0, 8'h08);
        irq_src = 8'h08;
        step(4);
        chk_req("b_first", 1'b1, 3'd3, 16'h0008);
        ack();
        step(2);
        chk("b_in_service", 16'(irq_req), 16'h0);
        reti();
        step(1);
        chk_req("b_rereq", 1'b1, 3'd3, 16'h0008);
        irq_src = 8'h00;
        step(3);
        rd_chk("b_pend_drop", 2'd2, 8'h00);
        chk("b_req_stays", 16'(irq_req), 16'h1);
        ack(); reti();
        step(3);
        chk("b_no_more", 16'(irq_req), 16'h0);
        wr(2'd1, 8'hFF);

        // Nesting: 4 in service, 1 preempts, 6 waits for both retis.
        wr(2'd0, 8'h52);
        pulse_src(8'h10);
        step(3);
        chk_req("c_id4", 1'b1, 3'd4, 16'h000A);
        ack();
        pulse_src(8'h02);
        step(3);
        chk_req("c_id1", 1'b1, 3'd1, 16'h0004);
        ack();
        pulse_src(8'h40);
        step(3);
        chk("c_id6_blocked", 16'(irq_req), 16'h0);
        rd_chk("c_pend", 2'd2, 8'h40);
        reti();
        step(2);
        chk("c_still_blocked", 16'(irq_req), 16'h0);
        reti();
        step(1);
        chk_req("c_id6", 1'b1, 3'd6, 16'h000E);
        ack(); reti();

        // Timeslice on channel 7 with period 3.
        wr(2'd0, 8'h80);
        wr(2'd3, 8'h03);
        for (int t = 0; t < 3; t++) do_tick();
        rd_chk("d_pend_3ticks", 2'd2, 8'h00);
        tick = 1'b1; step(1); tick = 1'b0;
        rd_chk("d_pend_4th", 2'd2, 8'h80);
        step(1);
        chk_req("d_slice_req", 1'b1, 3'd7, 16'h0010);
        ack();
        chk("d_ack_req", 16'(irq_req), 16'h0);
        reti();
        sreg_i = 1'b0;
        for (int t = 0; t < 5; t++) do_tick();
        rd_chk("d_hold_sreg0", 2'd2, 8'h00);
        sreg_i = 1'b1;
        for (int t = 0; t < 3; t++) do_tick();
        rd_chk("d_resume_3", 2'd2, 8'h00);
        tick = 1'b1; step(1); tick = 1'b0;
        rd_chk("d_resume_4", 2'd2, 8'h80);
        wr(2'd3, 8'h00);
        chk_req("d_slice_req2", 1'b1, 3'd7, 16'h0010);
        ack(); reti();

        // Ack coinciding with a fresh edge on channel 0.
        wr(2'd0, 8'h01);
        pulse_src(8'h01);
        step(3);
        chk_req("e_first", 1'b1, 3'd0, 16'h0002);
        pulse_src(8'h01);
        step(1);
        ack();
        chk("e_ack_req", 16'(irq_req), 16'h0);
        rd_chk("e_pend_kept", 2'd2, 8'h01);
        step(2);
        chk("e_isr_blocks", 16'(irq_req), 16'h0);
        reti();
        step(1);
        chk_req("e_rereq", 1'b1, 3'd0, 16'h0002);
        pulse_src(8'h01);
        step(1);
        ack();
        rd_chk("e_pend_kept2", 2'd2, 8'h01);
        wr(2'd2, 8'h01);
        rd_chk("e_pend_wclr", 2'd2, 8'h00);
        reti();
        step(2);
        chk("e_no_rereq", 16'(irq_req), 16'h0);

        // Ack while idle must not touch pending or ISR.
        cpu_idle = 1'b0;
        pulse_src(8'h01);
        step(3);
        chk("f_no_req_busy", 16'(irq_req), 16'h0);
        ack();
        rd_chk("f_pend_after_idle_ack", 2'd2, 8'h01);
        cpu_idle = 1'b1;
        step(1);
        chk_req("f_req", 1'b1, 3'd0, 16'h0002);

        // Asynchronous reset while a request is outstanding.
        #3;
        reset = 1'b1;
        #1;
        chk("g_rst_req", 16'(irq_req), 16'h0);
        chk("g_rst_id", 16'(irq_id), 16'h0);
        chk("g_rst_vec", irq_vector, 16'h0);
        rd_chk("g_rst_enable", 2'd0, 8'h00);
        rd_chk("g_rst_mode", 2'd1, 8'hFF);
        step(2);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
